enc_parity_appender16: RTL

Systematic cyclic-code parity generator for the encoder datapath; sits directly downstream of the 32-to-16 encoder width converter and consumes its 16-bit stream. Each data word is forwarded unchanged while a 16-bit-parallel LFSR accumulates the remainder of M(x)·x^P mod g(x). After the frame's last data word it appends P/16 parity words, MSB first, and marks the final parity word as frame last.

---
 rtl/enc_pkg.sv | 39 +++
 rtl/enc_parity_lfsr16.sv | 24 ++
 rtl/enc_parity_appender16.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// enc_pkg
// Shared definitions for the encoder datapath blocks.
//   enc_state_t      : parity appender FSM states (S_Data, S_Parity)
//   MaxParityLength  : widest remainder the shared LFSR helper can handle
//   WordWidth        : width of one stream word (bits shifted per LFSR step)
//   lfsr_step16()    : advances a P-bit remainder register by one 16-bit word
package enc_pkg;

  typedef enum logic {
    S_Data   = 1'b0,
    S_Parity = 1'b1
  } enc_state_t;

  localparam int MaxParityLength = 256;
  localparam int WordWidth       = 16;

  // Runs the serial division recurrence once per data bit, MSB of the word
  // first. The vectors are carried at MaxParityLength so one function serves
  // every remainder length; p selects the active low bits, and everything
  // above p-1 is masked off after each step so the x^P term never leaks in.
  function automatic logic [MaxParityLength-1:0] lfsr_step16(
    input logic [MaxParityLength-1:0] r,
    input logic [WordWidth-1:0]       d,
    input logic [MaxParityLength-1:0] poly,
    input int                         p
  );
    logic [MaxParityLength-1:0] acc;
    logic [MaxParityLength-1:0] mask;
    logic                       fb;
    mask = {MaxParityLength{1'b1}} >> (MaxParityLength - p);
    acc  = r & mask;
    for (int i = WordWidth - 1; i >= 0; i--) begin
      fb  = d[i] ^ acc[p-1];
      acc = ((acc << 1) ^ (fb ? (poly & mask) : '0)) & mask;
    end
    return acc;
  endfunction

endpackage

// File: rtl/enc_parity_lfsr16.sv
// enc_parity_lfsr16
// Combinational next-remainder network: folds one 16-bit word into the
// running remainder of M(x)*x^P mod g(x), bit 15 first.
//   remainder      in  P   current remainder register
//   data           in  16  word being absorbed
//   next_remainder out P   remainder after absorbing the word
module enc_parity_lfsr16
  import enc_pkg::*;
#(
  parameter int                      ParityLength = 64,
  parameter logic [ParityLength-1:0] GenPoly      = 64'h42F0E1EBA9EA3693
) (
  input  logic [ParityLength-1:0] remainder,
  input  logic [WordWidth-1:0]    data,
  output logic [ParityLength-1:0] next_remainder
);

  // The helper works at the package's maximum width; the result is narrowed
  // back to the configured remainder length.
  assign next_remainder = ParityLength'(lfsr_step16(MaxParityLength'(remainder), data,
                                                    MaxParityLength'(GenPoly),
                                                    ParityLength));

endmodule

// File: rtl/enc_parity_appender16.sv
// enc_parity_appender16
// Systematic cyclic-code parity generator. Data words pass straight through
// a single output register slice while the remainder of M(x)*x^P mod g(x)
// accumulates; after the frame's last data word, P/16 parity words are
// appended MSB first and the final one is flagged as frame last.
//   iClock         in  1   clock
//   iReset         in  1   synchronous active-high reset
//   iSrcDataValid  in  1   upstream word valid
//   iSrcDataLast   in  1   last data word of the frame
//   iSrcData       in  16  data word, bit 15 is the first polynomial bit
//   oSrcReady      out 1   word accepted this cycle (combinational from iDstReady)
//   oDstDataValid  out 1   output word valid
//   oDstDataLast   out 1   last parity word of the frame
//   oDstParity     out 1   output word is parity
//   oDstData       out 16  output word
//   iDstReady      in  1   downstream accepts the output word
module enc_parity_appender16
  import enc_pkg::*;
#(
  parameter int                      DataWidth    = 16,
  parameter int                      ParityLength = 64,
  parameter logic [ParityLength-1:0] GenPoly      = 64'h42F0E1EBA9EA3693
) (
  input  logic                 iClock,
  input  logic                 iReset,
  input  logic                 iSrcDataValid,
  input  logic                 iSrcDataLast,
  input  logic [DataWidth-1:0] iSrcData,
  output logic                 oSrcReady,
  output logic                 oDstDataValid,
  output logic                 oDstDataLast,
  output logic                 oDstParity,
  output logic [DataWidth-1:0] oDstData,
  input  logic                 iDstReady
);

  localparam int NumParityWords = ParityLength / DataWidth;
  localparam int CntWidth       = (NumParityWords > 1) ? $clog2(NumParityWords) : 1;
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(NumParityWords - 1);

  enc_state_t state, state_next;

  logic [ParityLength-1:0] lfsr, lfsr_next, lfsr_updated;
  logic [ParityLength-1:0] parity_sr, parity_sr_next;
  logic [CntWidth-1:0]     parity_cnt, parity_cnt_next;

  logic [DataWidth-1:0] out_data, out_data_next;
  logic                 out_valid, out_valid_next;
  logic                 out_last, out_last_next;
  logic                 out_parity, out_parity_next;

  logic slice_free;
  logic src_ready;
  logic accept;
  logic final_parity;

  // The slice can take a new word when it is empty or its current word is
  // leaving this cycle; upstream is only offered that slot in the data phase.
  assign slice_free   = !out_valid || iDstReady;
  assign src_ready    = (state == S_Data) && slice_free;
  assign accept       = iSrcDataValid && src_ready;
  assign final_parity = (parity_cnt == LastCnt);

  enc_parity_lfsr16 #(
    .ParityLength (ParityLength),
    .GenPoly      (GenPoly)
  ) u_lfsr (
    .remainder      (lfsr),
    .data           (iSrcData),
    .next_remainder (lfsr_updated)
  );

  // State and datapath registers. Reset discards any partial frame: the
  // remainder, the pending parity and the output slice all return to zero.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state      <= S_Data;
      lfsr       <= '0;
      parity_sr  <= '0;
      parity_cnt <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_parity <= 1'b0;
    end else begin
      state      <= state_next;
      lfsr       <= lfsr_next;
      parity_sr  <= parity_sr_next;
      parity_cnt <= parity_cnt_next;
      out_data   <= out_data_next;
      out_valid  <= out_valid_next;
      out_last   <= out_last_next;
      out_parity <= out_parity_next;
    end
  end

  // Next-state and datapath decisions. Everything holds by default, which is
  // what makes back-pressure freeze the block exactly; a free slice with
  // nothing new to load simply goes invalid.
  always_comb begin
    state_next      = state;
    lfsr_next       = lfsr;
    parity_sr_next  = parity_sr;
    parity_cnt_next = parity_cnt;
    out_data_next   = out_data;
    out_valid_next  = out_valid;
    out_last_next   = out_last;
    out_parity_next = out_parity;

    if (slice_free) begin
      out_valid_next  = 1'b0;
      out_last_next   = 1'b0;
      out_parity_next = 1'b0;
    end

    case (state)
      S_Data: begin
        if (accept) begin
          out_data_next   = iSrcData;
          out_valid_next  = 1'b1;
          out_last_next   = 1'b0;
          out_parity_next = 1'b0;
          lfsr_next       = lfsr_updated;
          // The remainder including the last word becomes the parity to
          // emit; the accumulator restarts clean for the next frame.
          if (iSrcDataLast) begin
            parity_sr_next  = lfsr_updated;
            lfsr_next       = '0;
            parity_cnt_next = '0;
            state_next      = S_Parity;
          end
        end
      end

      S_Parity: begin
        if (slice_free) begin
          out_data_next   = parity_sr[ParityLength-1 -: DataWidth];
          out_valid_next  = 1'b1;
          out_parity_next = 1'b1;
          out_last_next   = final_parity;
          parity_sr_next  = parity_sr << DataWidth;
          parity_cnt_next = parity_cnt + 1'b1;
          if (final_parity) begin
            state_next = S_Data;
          end
        end
      end

      default: begin
        state_next = S_Data;
      end
    endcase
  end

  assign oSrcReady     = src_ready;
  assign oDstDataValid = out_valid;
  assign oDstDataLast  = out_last;
  assign oDstParity    = out_parity;
  assign oDstData      = out_data;

endmodule
